dmem_arbiter: RTL and testbench

//  Shares the single-port data memory (async read, sync byte/half/word write) between the core

---
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: core (C) versus loader/DMA (D).
// Checks legality before touching memory, returns registered status/data one cycle later.
module dmem_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 256,
  parameter int unsigned MAX_WAIT = 4,
  localparam int unsigned LOGSIZE = $clog2(SIZE),
  localparam int unsigned AW      = LOGSIZE + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [2:0]       c_funct3,
  input  logic [AW-1:0]    c_addr,
  input  logic [WIDTH-1:0] c_wdata,
  output logic             c_gnt,
  output logic             c_rvalid,
  output logic [WIDTH-1:0] c_rdata,
  output logic             c_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [2:0]       d_funct3,
  input  logic [AW-1:0]    d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic             d_lock,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_err,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_data_in,
  output logic             mem_wr_en,
  output logic [2:0]       mem_funct3,
  input  logic [WIDTH-1:0] mem_data_out
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MaxWait = CW'(MAX_WAIT);

  typedef enum logic [0:0] {StArb, StLock} state_e;

  state_e          state_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            c_rvalid_q, c_err_q, d_rvalid_q, d_err_q;
  logic [WIDTH-1:0] c_rdata_q, d_rdata_q;
  logic            c_win, d_win;
  logic            c_ok, d_ok;

  // Funct3 and natural alignment check; stores only allow SB/SH/SW.
  function automatic logic legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ok_f3;
    if (we) ok_f3 = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    ok_f3 = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
    case (f3[1:0])
      2'b01:   return ok_f3 && !a[0];
      2'b10:   return ok_f3 && (a == 2'b00);
      default: return ok_f3;
    endcase
  endfunction

  assign c_ok = legal(c_we, c_funct3, c_addr[1:0]);
  assign d_ok = legal(d_we, d_funct3, d_addr[1:0]);

  always_comb begin
    c_win = 1'b0;
    d_win = 1'b0;
    if (!rst) begin
      if (state_q == StLock) begin
        d_win = d_req;
      end else if (c_req && d_req) begin
        // Core has priority until the DMA has starved for MAX_WAIT cycles.
        d_win = (wait_cnt_q == MaxWait);
        c_win = !d_win;
      end else begin
        c_win = c_req;
        d_win = d_req;
      end
    end
  end

  assign c_gnt       = c_win;
  assign d_gnt       = d_win;
  assign mem_addr    = d_win ? d_addr   : c_addr;
  assign mem_data_in = d_win ? d_wdata  : c_wdata;
  assign mem_funct3  = d_win ? d_funct3 : c_funct3;
  assign mem_wr_en   = (c_win && c_we && c_ok) || (d_win && d_we && d_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StArb;
      wait_cnt_q <= '0;
      c_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      c_rvalid_q <= c_win;
      c_err_q    <= c_win && !c_ok;
      c_rdata_q  <= (c_win && c_ok && !c_we) ? mem_data_out : '0;
      d_rvalid_q <= d_win;
      d_err_q    <= d_win && !d_ok;
      d_rdata_q  <= (d_win && d_ok && !d_we) ? mem_data_out : '0;

      if (d_win) begin
        wait_cnt_q <= '0;
      end else if (d_req && (wait_cnt_q != MaxWait)) begin
        wait_cnt_q <= wait_cnt_q + CW'(1);
      end

      case (state_q)
        StArb:   if (d_win && d_lock) state_q <= StLock;
        StLock:  if (!d_lock) state_q <= StArb;
        default: state_q <= StArb;
      endcase
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign c_err    = c_err_q;
  assign c_rdata  = c_rdata_q;
  assign d_rvalid = d_rvalid_q;
  assign d_err    = d_err_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset-in-lock sequence, then randomized
// traffic checked against a byte-array memory model with simple arbitration bookkeeping.
module tb_dmem_arbiter;

  localparam int unsigned SIZE = 256;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned AW = $clog2(SIZE) + 2;
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4;
  localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

  logic clk, rst;
  logic c_req, c_we, c_gnt, c_rvalid, c_err;
  logic [2:0] c_funct3;
  logic [AW-1:0] c_addr;
  logic [31:0] c_wdata, c_rdata;
  logic d_req, d_we, d_lock, d_gnt, d_rvalid, d_err;
  logic [2:0] d_funct3;
  logic [AW-1:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_data_in, mem_data_out;
  logic mem_wr_en;
  logic [2:0] mem_funct3;

  dmem_arbiter #(.WIDTH(32), .SIZE(SIZE), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr_en(mem_wr_en),
    .mem_funct3(mem_funct3), .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'h5A3C_96E1;
  endfunction

  // Stand-in for data_memory: async formatted read, sync byte/half/word write.
  logic [31:0] mem_w [SIZE];

  always_comb begin
    logic [31:0] w;
    logic [7:0] bsel;
    logic [15:0] hsel;
    w = mem_w[mem_addr[AW-1:2]];
    bsel = 8'(w >> (8 * mem_addr[1:0]));
    hsel = 16'(w >> (16 * mem_addr[1]));
    case (mem_funct3)
      3'd0:    mem_data_out = {{24{bsel[7]}}, bsel};
      3'd1:    mem_data_out = {{16{hsel[15]}}, hsel};
      3'd4:    mem_data_out = {24'd0, bsel};
      3'd5:    mem_data_out = {16'd0, hsel};
      default: mem_data_out = w;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) mem_w[i] <= init_word(i);
    end else if (mem_wr_en) begin
      case (mem_funct3[1:0])
        2'd0:    mem_w[mem_addr[AW-1:2]][8 * mem_addr[1:0] +: 8] <= mem_data_in[7:0];
        2'd1:    mem_w[mem_addr[AW-1:2]][16 * mem_addr[1] +: 16] <= mem_data_in[15:0];
        default: mem_w[mem_addr[AW-1:2]] <= mem_data_in;
      endcase
    end
  end

  typedef struct {
    logic cr, cw; logic [2:0] cf; logic [AW-1:0] ca; logic [31:0] cd;
    logic dr, dw; logic [2:0] df; logic [AW-1:0] da; logic [31:0] dd; logic dl;
    logic cg, dg, wr;
    logic crv, cer; logic [31:0] crd;
    logic drv, der; logic [31:0] drd;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t row(
      input logic cr, input logic cw, input logic [2:0] cf, input logic [AW-1:0] ca,
      input logic [31:0] cd, input logic dr, input logic dw, input logic [2:0] df,
      input logic [AW-1:0] da, input logic [31:0] dd, input logic dl,
      input logic cg, input logic dg, input logic wr,
      input logic crv, input logic cer, input logic [31:0] crd,
      input logic drv, input logic der, input logic [31:0] drd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.cf = cf; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.df = df; v.da = da; v.dd = dd; v.dl = dl;
    v.cg = cg; v.dg = dg; v.wr = wr;
    v.crv = crv; v.cer = cer; v.crd = crd;
    v.drv = drv; v.der = der; v.drd = drd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  // Drive at negedge, check grants mid-cycle, check responses just after the next posedge.
  task automatic apply(input vec_t v, input logic r);
    rst = r;
    c_req = v.cr; c_we = v.cw; c_funct3 = v.cf; c_addr = v.ca; c_wdata = v.cd;
    d_req = v.dr; d_we = v.dw; d_funct3 = v.df; d_addr = v.da; d_wdata = v.dd; d_lock = v.dl;
    #1;
    check("c_gnt", 32'(c_gnt), 32'(v.cg));
    check("d_gnt", 32'(d_gnt), 32'(v.dg));
    check("mem_wr_en", 32'(mem_wr_en), 32'(v.wr));
    if (v.cg || v.dg) check("mem_addr", 32'(mem_addr), 32'(v.dg ? v.da : v.ca));
    @(posedge clk);
    #1;
    check("c_rvalid", 32'(c_rvalid), 32'(v.crv));
    check("c_err", 32'(c_err), 32'(v.cer));
    check("d_rvalid", 32'(d_rvalid), 32'(v.drv));
    check("d_err", 32'(d_err), 32'(v.der));
    if (v.crv || r) check("c_rdata", c_rdata, v.crd);
    if (v.drv || r) check("d_rdata", d_rdata, v.drd);
    @(negedge clk);
  endtask

  // Reference model state: byte-addressed memory, lock flag, count of starved DMA cycles.
  logic [7:0] ref_b [SIZE*4];
  bit model_locked;
  int model_denied;

  task automatic model_reset();
    for (int b = 0; b < SIZE * 4; b++) ref_b[b] = 8'(init_word(b / 4) >> (8 * (b % 4)));
    model_locked = 1'b0;
    model_denied = 0;
  endtask

  function automatic bit ref_legal(input logic we, input logic [2:0] f3, input int a);
    int sz;
    if (we && f3 > 2) return 1'b0;
    if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    sz = 1 << f3[1:0];
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
    int sz;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    v = 0;
    for (int k = 0; k < sz; k++) v = v | (32'(ref_b[a + k]) << (8 * k));
    if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input int a, input logic [31:0] wd);
    for (int k = 0; k < (1 << f3[1:0]); k++) ref_b[a + k] = 8'(wd >> (8 * k));
  endtask

  vec_t tbl[$];
  vec_t idle_v, v;
  logic [2:0] f3_pool [8];
  bit cl, dl_ok;

  initial begin
    f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
    rst = 1'b1;
    idle_v = row(1, 0, LW, 'h0, 0, 1, 0, LW, 'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(idle_v, 1'b0 | 1'b1);
    apply(idle_v, 1'b1);

    // C: req we f3 addr wdata | D: req we f3 addr wdata lock | cg dg wr | crv cer crd | drv der drd
    tbl.push_back(row(1, 1, SW, 'h0C, 'hDEADBEEF, 0, 0, LW, 0, 0, 0,
                      1, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 0, LW, 'h0C, 0, 0, 0, LW, 0, 0, 0,
                      1, 0, 0, 1, 0, 'hDEADBEEF, 0, 0, 0));
    tbl.push_back(row(1, 1, SB, 'h0C, 'h10, 0, 0, LW, 0, 0, 0,
                      1, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, LW, 0, 0, 1, 0, LBU, 'h0C, 0, 0,
                      0, 1, 0, 0, 0, 0, 1, 0, 'h10));
    tbl.push_back(row(1, 1, SB, 'h38, 'hF0, 0, 0, LW, 0, 0, 0,
                      1, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 0, LB, 'h38, 0, 0, 0, LW, 0, 0, 0,
                      1, 0, 0, 1, 0, 'hFFFFFFF0, 0, 0, 0));
    tbl.push_back(row(1, 1, SW, 'h04, 'h11223344, 0, 0, LW, 0, 0, 0,
                      1, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 0, LW, 'h06, 0, 0, 0, LW, 0, 0, 0,
                      1, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 1, SH, 'h03, 'hFFFFFFFF, 0, 0, LW, 0, 0, 0,
                      1, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 1, 3'd4, 'h04, 'hFFFFFFFF, 0, 0, LW, 0, 0, 0,
                      1, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 0, LW, 'h04, 0, 0, 0, LW, 0, 0, 0,
                      1, 0, 0, 1, 0, 'h11223344, 0, 0, 0));
    tbl.push_back(row(1, 0, 3'd3, 'h00, 0, 0, 0, LW, 0, 0, 0,
                      1, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, LW, 0, 0, 1, 0, LH, 'h01, 0, 0,
                      0, 1, 0, 0, 0, 0, 1, 1, 0));
    // Continuous contention: four core grants, one DMA grant, four core grants.
    for (int i = 0; i < 9; i++) begin
      if (i == 4)
        tbl.push_back(row(1, 0, LW, 'h0C, 0, 1, 0, LW, 'h04, 0, 0,
                          0, 1, 0, 0, 0, 0, 1, 0, 'h11223344));
      else
        tbl.push_back(row(1, 0, LW, 'h0C, 0, 1, 0, LW, 'h04, 0, 0,
                          1, 0, 0, 1, 0, 'hDEADBE10, 0, 0, 0));
    end
    // DMA wins after starving, then holds the memory for a locked 3-write burst.
    tbl.push_back(row(1, 0, LW, 'h0C, 0, 1, 1, SW, 'h00, 'hA0, 1,
                      0, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(row(1, 0, LW, 'h0C, 0, 1, 1, SW, 'h04, 'hA4, 1,
                      0, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(row(1, 0, LW, 'h0C, 0, 1, 1, SW, 'h08, 'hA8, 0,
                      0, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(row(1, 0, LW, 'h0C, 0, 1, 0, LW, 'h00, 0, 0,
                      1, 0, 0, 1, 0, 'hDEADBE10, 0, 0, 0));
    tbl.push_back(row(1, 0, LW, 'h08, 0, 1, 0, LW, 'h00, 0, 0,
                      1, 0, 0, 1, 0, 'hA8, 0, 0, 0));
    tbl.push_back(row(0, 0, LW, 0, 0, 1, 0, LW, 'h00, 0, 0,
                      0, 1, 0, 0, 0, 0, 1, 0, 'hA0));
    foreach (tbl[i]) apply(tbl[i], 1'b0);

    // Reset in the middle of a locked burst.
    apply(row(0, 0, LW, 0, 0, 1, 0, LW, 'h00, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 'hA0), 1'b0);
    apply(row(1, 0, LW, 'h0C, 0, 1, 0, LW, 'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    apply(row(1, 0, LW, 'h0C, 0, 1, 0, LW, 'h00, 0, 1,
              1, 0, 0, 1, 0, init_word(3), 0, 0, 0), 1'b0);

    // Randomized traffic against the reference model.
    apply(idle_v, 1'b1);
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      v = idle_v;
      v.cr = ($urandom_range(0, 9) < 7); v.cw = $urandom_range(0, 1);
      v.cf = f3_pool[$urandom_range(0, 7)]; v.ca = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 6) v.ca[1:0] = 2'b00;
      v.cd = $urandom;
      v.dr = ($urandom_range(0, 9) < 7); v.dw = $urandom_range(0, 1);
      v.df = f3_pool[$urandom_range(0, 7)]; v.da = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 6) v.da[1:0] = 2'b00;
      v.dd = $urandom; v.dl = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) begin
        apply(v, 1'b1);
        model_reset();
      end else begin
        if (model_locked) begin
          v.dg = v.dr; v.cg = 1'b0;
        end else if (v.cr && v.dr) begin
          v.dg = (model_denied >= MAX_WAIT); v.cg = !v.dg;
        end else begin
          v.cg = v.cr; v.dg = v.dr;
        end
        cl = ref_legal(v.cw, v.cf, int'(v.ca));
        dl_ok = ref_legal(v.dw, v.df, int'(v.da));
        v.wr = (v.cg && v.cw && cl) || (v.dg && v.dw && dl_ok);
        v.crv = v.cg; v.cer = v.cg && !cl;
        v.crd = (v.cg && cl && !v.cw) ? ref_load(v.cf, int'(v.ca)) : 0;
        v.drv = v.dg; v.der = v.dg && !dl_ok;
        v.drd = (v.dg && dl_ok && !v.dw) ? ref_load(v.df, int'(v.da)) : 0;
        if (v.cg && cl && v.cw) ref_store(v.cf, int'(v.ca), v.cd);
        if (v.dg && dl_ok && v.dw) ref_store(v.df, int'(v.da), v.dd);
        if (v.dg) model_denied = 0;
        else if (v.dr && model_denied < MAX_WAIT) model_denied++;
        model_locked = model_locked ? v.dl : (v.dg && v.dl);
        apply(v, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
